// File: rtl/reg_list_sequencer_pkg.sv
// Shared types and constants for the LDM/STM register-list sequencer.
// Holds the FSM encoding and the block-transfer address arithmetic.
package reg_list_sequencer_pkg;

    localparam int LIST_W = 16;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } seqState_t;

    // First beat address for IA/IB/DA/DB; span is 4*n bytes.
    function automatic logic [31:0] startAddress(
        input logic [31:0] base,
        input logic [31:0] span,
        input logic        p,
        input logic        u
    );
        logic [31:0] step;
        step = 32'(WORD_BYTES);
        unique case ({p, u})
            2'b01:   startAddress = base;
            2'b11:   startAddress = base + step;
            2'b00:   startAddress = base - span + step;
            default: startAddress = base - span;
        endcase
    endfunction

    function automatic logic [31:0] writebackAddress(
        input logic [31:0] base,
        input logic [31:0] span,
        input logic        u
    );
        writebackAddress = u ? (base + span) : (base - span);
    endfunction

endpackage

// File: rtl/reg_list_sequencer_lowest_set_bit.sv
// Priority pick of the lowest set bit of a 16-bit register list.
// Produces a 32-bit one-hot, its binary index and an any-set flag.
module lowest_set_bit (
    input  logic [15:0] Vec,
    output logic [31:0] OneHot,
    output logic [3:0]  Idx,
    output logic        Any
);

    always_comb begin
        OneHot = '0;
        Idx    = '0;
        Any    = |Vec;
        // Scan downward so the lowest set bit is written last.
        for (int i = 15; i >= 0; i--) begin
            if (Vec[i]) begin
                OneHot = 32'd1 << i;
                Idx    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/reg_list_sequencer.sv
// LDM/STM register-list sequencer: issues one beat per listed register
// in ascending order with word addresses and the base writeback value.
module reg_list_sequencer #(
    parameter int LIST_W = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [LIST_W-1:0] RegList,
    input  logic [31:0]       Base,
    input  logic              P,
    input  logic              U,
    input  logic              Ack,
    output logic              Busy,
    output logic              Valid,
    output logic [31:0]       OneHot,
    output logic [3:0]        RegIdx,
    output logic [31:0]       Addr,
    output logic              Last,
    output logic              Done,
    output logic [31:0]       WbAddr,
    output logic [4:0]        Count
);

    import reg_list_sequencer_pkg::*;

    seqState_t         state;
    seqState_t         stateNext;
    logic [LIST_W-1:0] pending;
    logic [LIST_W-1:0] pendingNext;
    logic [4:0]        listCount;
    logic [31:0]       span;
    logic [31:0]       step;
    logic              load;
    logic              advance;
    logic [31:0]       nextOneHot;
    logic [3:0]        nextIdx;
    logic              nextAny;

    assign step    = 32'(WORD_BYTES);
    assign load    = (state == IDLE) && Start;
    assign Valid   = (state == RUN);
    assign advance = Valid && Ack;
    assign Busy    = (state != IDLE);
    assign Done    = (state == FIN);
    assign Last    = Valid && (pending != '0)
                   && ((pending & (pending - LIST_W'(1))) == '0);

    always_comb begin
        listCount = '0;
        for (int i = 0; i < LIST_W; i++) begin
            listCount = listCount + 5'(RegList[i]);
        end
    end

    assign span = 32'(listCount) * step;

    // The registered OneHot always mirrors the lowest pending bit in RUN.
    always_comb begin
        pendingNext = pending;
        if (load) begin
            pendingNext = RegList;
        end else if (advance) begin
            pendingNext = pending & ~OneHot[LIST_W-1:0];
        end
    end

    lowest_set_bit uPick (
        .Vec    (pendingNext),
        .OneHot (nextOneHot),
        .Idx    (nextIdx),
        .Any    (nextAny)
    );

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    stateNext = (listCount != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (advance && Last) begin
                    stateNext = FIN;
                end
            end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pending <= '0;
            Addr    <= '0;
            WbAddr  <= '0;
            Count   <= '0;
            OneHot  <= '0;
            RegIdx  <= '0;
        end else begin
            pending <= pendingNext;
            if (load) begin
                Addr   <= startAddress(Base, span, P, U);
                WbAddr <= writebackAddress(Base, span, U);
                Count  <= listCount;
            end else if (advance) begin
                Addr <= Addr + step;
            end
            // Hold the last issued register once the list drains.
            if ((load || advance) && nextAny) begin
                OneHot <= nextOneHot;
                RegIdx <= nextIdx;
            end
        end
    end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Self-checking bench: vector table of transfers, scoreboard of beats.
// Hand sequences cover reset mid-transfer and restart.
module tb_reg_list_sequencer;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [15:0] RegList;
    logic [31:0] Base;
    logic        P;
    logic        U;
    logic        Ack;
    logic        Busy;
    logic        Valid;
    logic [31:0] OneHot;
    logic [3:0]  RegIdx;
    logic [31:0] Addr;
    logic        Last;
    logic        Done;
    logic [31:0] WbAddr;
    logic [4:0]  Count;

    reg_list_sequencer dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Start   (Start),
        .RegList (RegList),
        .Base    (Base),
        .P       (P),
        .U       (U),
        .Ack     (Ack),
        .Busy    (Busy),
        .Valid   (Valid),
        .OneHot  (OneHot),
        .RegIdx  (RegIdx),
        .Addr    (Addr),
        .Last    (Last),
        .Done    (Done),
        .WbAddr  (WbAddr),
        .Count   (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] regList;
        logic [31:0] base;
        logic        p;
        logic        u;
        logic [4:0]  expCount;
        logic [31:0] expFirst;
        logic [31:0] expWb;
        int          stall;
        bit          poke;
    } vec_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] addr;
        logic [31:0] oneHot;
        logic        last;
    } beat_t;

    vec_t  vecs[7];
    beat_t q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pushBeats(input vec_t v);
        int          n;
        int          rem;
        logic [31:0] a;
        beat_t       b;
        n = $countones(v.regList);
        case ({v.p, v.u})
            2'b01:   a = v.base;
            2'b11:   a = v.base + 32'd4;
            2'b00:   a = v.base - 32'(4 * n) + 32'd4;
            default: a = v.base - 32'(4 * n);
        endcase
        rem = n;
        for (int i = 0; i < 16; i++) begin
            if (v.regList[i]) begin
                b.idx    = 4'(i);
                b.addr   = a;
                b.oneHot = 32'd1 << i;
                b.last   = (rem == 1);
                q.push_back(b);
                a   = a + 32'd4;
                rem = rem - 1;
            end
        end
    endtask

    task automatic runXfer(input vec_t v);
        int          stall;
        int          cyc;
        bit          doneSeen;
        bit          firstSeen;
        beat_t       b;
        logic [31:0] lastHot;
        q.delete();
        pushBeats(v);
        stall     = v.stall;
        doneSeen  = 0;
        firstSeen = 0;
        lastHot   = '0;
        RegList   = v.regList;
        Base      = v.base;
        P         = v.p;
        U         = v.u;
        Start     = 1'b1;
        Ack       = 1'b1;
        tick();
        Start = 1'b0;
        check("busy_after_start", Busy, 1);
        check("count", Count, v.expCount);
        check("wb_addr", WbAddr, v.expWb);
        cyc = 0;
        while (!doneSeen && cyc < 80) begin
            if (Done) begin
                doneSeen = 1;
                if (v.expCount == 0) check("empty_done_latency", cyc, 0);
                check("done_valid_low", Valid, 0);
                check("done_wb_addr", WbAddr, v.expWb);
                check("done_count", Count, v.expCount);
            end else begin
                if (Valid) begin
                    if (q.size() == 0) begin
                        check("extra_beat_idx", RegIdx, 16);
                        Ack = 1'b1;
                    end else begin
                        b = q[0];
                        if (!firstSeen) check("first_addr", Addr, v.expFirst);
                        firstSeen = 1;
                        check("beat_idx", RegIdx, b.idx);
                        check("beat_addr", Addr, b.addr);
                        check("beat_onehot", OneHot, b.oneHot);
                        check("beat_last", Last, b.last);
                        if (v.poke && cyc == 0) begin
                            Start   = 1'b1;
                            RegList = 16'hFF00;
                            Base    = 32'h777;
                        end else begin
                            Start = 1'b0;
                        end
                        if (stall > 0) begin
                            Ack   = 1'b0;
                            stall = stall - 1;
                        end else begin
                            Ack     = 1'b1;
                            lastHot = b.oneHot;
                            void'(q.pop_front());
                        end
                    end
                end
                tick();
                cyc++;
            end
        end
        check("done_seen", doneSeen, 1);
        Start = 1'b0;
        tick();
        check("done_one_cycle", Done, 0);
        check("idle_busy", Busy, 0);
        check("idle_last", Last, 0);
        check("beats_left", q.size(), 0);
        check("idle_addr_hold", Addr,
              v.expFirst + 32'(4 * int'(v.expCount)));
        if (v.expCount != 0) check("idle_onehot_hold", OneHot, lastHot);
    endtask

    initial begin
        vecs[0] = '{16'h000B, 32'h100, 1'b0, 1'b1, 5'd3,
                    32'h100, 32'h10C, 0, 1'b0};
        vecs[1] = '{16'h8001, 32'h200, 1'b1, 1'b0, 5'd2,
                    32'h1F8, 32'h1F8, 0, 1'b0};
        vecs[2] = '{16'h0030, 32'h300, 1'b0, 1'b1, 5'd2,
                    32'h300, 32'h308, 3, 1'b0};
        vecs[3] = '{16'h0000, 32'h40, 1'b0, 1'b1, 5'd0,
                    32'h40, 32'h40, 0, 1'b0};
        vecs[4] = '{16'h0003, 32'hFFFFFFFC, 1'b1, 1'b1, 5'd2,
                    32'h0, 32'h4, 0, 1'b1};
        vecs[5] = '{16'h00F0, 32'h1000, 1'b0, 1'b0, 5'd4,
                    32'hFF4, 32'hFF0, 1, 1'b0};
        vecs[6] = '{16'hFFFF, 32'h0, 1'b0, 1'b1, 5'd16,
                    32'h0, 32'h40, 0, 1'b0};

        Rst_n   = 1'b0;
        Start   = 1'b0;
        RegList = '0;
        Base    = '0;
        P       = 1'b0;
        U       = 1'b0;
        Ack     = 1'b0;
        tick();
        tick();
        check("rst_busy", Busy, 0);
        check("rst_valid", Valid, 0);
        check("rst_last", Last, 0);
        check("rst_done", Done, 0);
        check("rst_onehot", OneHot, 0);
        check("rst_idx", RegIdx, 0);
        check("rst_addr", Addr, 0);
        check("rst_wb", WbAddr, 0);
        check("rst_count", Count, 0);
        Rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            runXfer(vecs[i]);
        end

        RegList = 16'hFFFF;
        Base    = 32'h500;
        P       = 1'b0;
        U       = 1'b1;
        Start   = 1'b1;
        Ack     = 1'b1;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        check("mid_idx", RegIdx, 5);
        check("mid_addr", Addr, 32'h514);
        Rst_n = 1'b0;
        tick();
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_valid", Valid, 0);
        check("mid_rst_done", Done, 0);
        check("mid_rst_last", Last, 0);
        check("mid_rst_onehot", OneHot, 0);
        check("mid_rst_idx", RegIdx, 0);
        check("mid_rst_addr", Addr, 0);
        check("mid_rst_wb", WbAddr, 0);
        check("mid_rst_count", Count, 0);
        Ack = 1'b0;
        tick();
        check("mid_rst_no_done", Done, 0);
        Rst_n = 1'b1;
        runXfer(vecs[6]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
